// File: rtl/canvas_painter_pkg.sv
// rtl/canvas_painter_pkg.sv - shared color constants and painter state type
// Contents: COLOR_WIDTH, COLOR_NONE and palette indices; painter_state_t;
//           safe_clog2 helper (never returns 0, so 1-wide fields stay legal).
package canvas_painter_pkg;

  localparam int COLOR_WIDTH = 4;

  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'd0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'd1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'd2;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'd3;
  localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 4'd4;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } painter_state_t;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brush_clip.sv
// rtl/brush_clip.sv - brush offset to canvas pixel, with bounds test
// Ports: cx/cy brush centre, dx/dy sweep offset (0..BRUSH-1);
//        in_bounds high when the target pixel lies on the canvas,
//        addr row-major y*WIDTH+x of the target (meaningless when clipped).
module brush_clip
  import canvas_painter_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int BRUSH  = 3,
  localparam int XW = safe_clog2(WIDTH),
  localparam int YW = safe_clog2(HEIGHT),
  localparam int DW = safe_clog2(BRUSH),
  localparam int AW = safe_clog2(WIDTH * HEIGHT)
) (
  input  logic [XW-1:0] cx,
  input  logic [YW-1:0] cy,
  input  logic [DW-1:0] dx,
  input  logic [DW-1:0] dy,
  output logic          in_bounds,
  output logic [AW-1:0] addr
);

  localparam int HALF = BRUSH / 2;

  // One extra bit so a pixel left of / above the canvas reads as negative.
  logic signed [XW:0] px;
  logic signed [YW:0] py;
  int px_i;
  int py_i;

  always_comb begin
    px   = $signed({1'b0, cx}) + $signed((XW + 1)'(dx)) - $signed((XW + 1)'(HALF));
    py   = $signed({1'b0, cy}) + $signed((YW + 1)'(dy)) - $signed((YW + 1)'(HALF));
    // Widen before comparing: WIDTH itself may not fit in XW+1 signed bits.
    px_i = int'(px);
    py_i = int'(py);
    in_bounds = (px_i >= 0) && (px_i < WIDTH) && (py_i >= 0) && (py_i < HEIGHT);
    addr      = AW'(py_i * WIDTH + px_i);
  end

endmodule

// File: rtl/canvas_painter.sv
// rtl/canvas_painter.sv - brush stamp and full clear writer for one canvas RAM
// Ports: clk, reset (async, active-high);
//        paint_valid/paint_ready with paint_x, paint_y, paint_color request;
//        clear_req full-canvas clear; busy while not IDLE;
//        wr_en/wr_addr/wr_data registered canvas RAM write port.
module canvas_painter
  import canvas_painter_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int BRUSH  = 3,
  localparam int XW = safe_clog2(WIDTH),
  localparam int YW = safe_clog2(HEIGHT),
  localparam int DW = safe_clog2(BRUSH),
  localparam int AW = safe_clog2(WIDTH * HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   paint_valid,
  output logic                   paint_ready,
  input  logic [XW-1:0]          paint_x,
  input  logic [YW-1:0]          paint_y,
  input  logic [COLOR_WIDTH-1:0] paint_color,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [COLOR_WIDTH-1:0] wr_data
);

  localparam int LAST_OFF = BRUSH - 1;
  localparam int LAST_A   = WIDTH * HEIGHT - 1;

  painter_state_t state, state_d;

  logic [XW-1:0]          cx;
  logic [YW-1:0]          cy;
  logic [COLOR_WIDTH-1:0] col;
  logic [DW-1:0]          dx;
  logic [DW-1:0]          dy;
  logic [AW-1:0]          a;

  logic                   sweep_last;
  logic                   clear_last;
  logic                   clip_in_bounds;
  logic [AW-1:0]          clip_addr;

  logic                   wr_en_d;
  logic [AW-1:0]          wr_addr_d;
  logic [COLOR_WIDTH-1:0] wr_data_d;

  brush_clip #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .BRUSH (BRUSH)
  ) u_clip (
    .cx       (cx),
    .cy       (cy),
    .dx       (dx),
    .dy       (dy),
    .in_bounds(clip_in_bounds),
    .addr     (clip_addr)
  );

  assign sweep_last = (dx == DW'(LAST_OFF)) && (dy == DW'(LAST_OFF));
  assign clear_last = (a == AW'(LAST_A));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; clear wins over a simultaneous paint
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
        end else if (paint_valid) begin
          state_d = PAINT;
        end
      end
      PAINT: begin
        if (sweep_last) begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (clear_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshake plus the values the write port takes next edge
  always_comb begin
    paint_ready = (state == IDLE) && !clear_req;
    busy        = (state != IDLE);
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    case (state)
      PAINT: begin
        // Clipped offsets still take their cycle, just without a write
        wr_en_d   = clip_in_bounds;
        wr_addr_d = clip_addr;
        wr_data_d = col;
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = a;
        wr_data_d = COLOR_NONE;
      end
      default: ;
    endcase
  end

  // Request latch, sweep counters and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx      <= '0;
      cy      <= '0;
      col     <= COLOR_NONE;
      dx      <= '0;
      dy      <= '0;
      a       <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= COLOR_NONE;
    end else begin
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      case (state)
        IDLE: begin
          a <= '0;
          if (paint_valid && paint_ready) begin
            cx  <= paint_x;
            cy  <= paint_y;
            col <= paint_color;
            dx  <= '0;
            dy  <= '0;
          end
        end
        PAINT: begin
          if (dx == DW'(LAST_OFF)) begin
            dx <= '0;
            dy <= dy + 1'b1;
          end else begin
            dx <= dx + 1'b1;
          end
        end
        CLEAR: begin
          a <= a + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_painter.sv
// tb/tb_canvas_painter.sv - scoreboard bench for canvas_painter on an 8x8 canvas
module tb_canvas_painter;
  import canvas_painter_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
  localparam int B = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   paint_valid = 1'b0;
  logic                   paint_ready;
  logic [2:0]             paint_x = '0;
  logic [2:0]             paint_y = '0;
  logic [COLOR_WIDTH-1:0] paint_color = '0;
  logic                   clear_req = 1'b0;
  logic                   busy;
  logic                   wr_en;
  logic [5:0]             wr_addr;
  logic [COLOR_WIDTH-1:0] wr_data;

  canvas_painter #(.WIDTH(W), .HEIGHT(H), .BRUSH(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .paint_valid(paint_valid),
    .paint_ready(paint_ready),
    .paint_x    (paint_x),
    .paint_y    (paint_y),
    .paint_color(paint_color),
    .clear_req  (clear_req),
    .busy       (busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every write the DUT presents must be the next expected one, on its cycle
  exp_t e;
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: addr %0d data %0d cycle %0d, expected no write",
                 wr_addr, wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(wr_addr) == e.addr && int'(wr_data) == e.data && cyc == e.cyc) passed++;
        else $display("FAIL write: addr %0d data %0d cycle %0d, expected addr %0d data %0d cycle %0d",
                      wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
      end
    end
  end

  // Reference model: brush pixels in sweep order, clipped, with their presentation cycle
  task automatic push_paint(input int x, input int y, input int c, input int acc);
    for (int oy = 0; oy < B; oy++) begin
      for (int ox = 0; ox < B; ox++) begin
        int px = x + ox - B / 2;
        int py = y + oy - B / 2;
        if (px >= 0 && px < W && py >= 0 && py < H)
          exp_q.push_back('{addr: py * W + px, data: c, cyc: acc + 1 + oy * B + ox});
      end
    end
  endtask

  task automatic push_clear(input int acc);
    for (int i = 0; i < W * H; i++)
      exp_q.push_back('{addr: i, data: int'(COLOR_NONE), cyc: acc + 1 + i});
  endtask

  // Request already on the inputs: wait for acceptance, then follow the sweep
  task automatic run_paint(input int x, input int y, input int c, output int acc);
    int waited = 0;
    int low = 0;
    bit busy_ok = 1'b1;
    while (!paint_ready && waited < 300) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!paint_ready) begin
      check("accept_timeout", 1'b0, 0, 1);
      paint_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    push_paint(x, y, c, acc);
    @(posedge clk); #1;
    paint_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (busy != !paint_ready) busy_ok = 1'b0;
      if (paint_ready || low >= 300) break;
      low++;
    end
    check("ready_low_cycles", low == B * B, low, B * B);
    check("busy_tracks_ready", busy_ok, busy_ok, 1);
    @(negedge clk); #1;
    check("paint_queue_drained", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  task automatic do_paint(input int x, input int y, input int c);
    int acc;
    @(negedge clk);
    paint_x     = 3'(x);
    paint_y     = 3'(y);
    paint_color = COLOR_WIDTH'(c);
    paint_valid = 1'b1;
    #1;
    run_paint(x, y, c, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int clr_acc;
    int acc;
    int waited;

    // 1: reset and idle
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_wr_en", wr_en == 1'b0, wr_en, 0);
    check("reset_wr_addr", wr_addr == 6'd0, wr_addr, 0);
    check("reset_wr_data", wr_data == COLOR_NONE, wr_data, COLOR_NONE);
    check("reset_ready", paint_ready == 1'b1, paint_ready, 1);
    check("reset_busy", busy == 1'b0, busy, 0);

    // 2-4: centre, top-left corner, bottom-right corner
    do_paint(4, 4, COLOR_RED);
    do_paint(0, 0, COLOR_BLUE);
    do_paint(7, 7, COLOR_GREEN);

    // Randomized paints, including edges
    for (int i = 0; i < 10; i++)
      do_paint($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(1, 15));

    // 5: clear and paint together; clear wins, paint waits
    @(negedge clk);
    clear_req   = 1'b1;
    paint_valid = 1'b1;
    paint_x     = 3'd2;
    paint_y     = 3'd5;
    paint_color = COLOR_WHITE;
    #1;
    check("ready_blocked_by_clear", paint_ready == 1'b0, paint_ready, 0);
    clr_acc = cyc + 1;
    push_clear(clr_acc);
    @(posedge clk); #1;
    clear_req = 1'b0;
    check("busy_in_clear", busy == 1'b1, busy, 1);
    run_paint(2, 5, COLOR_WHITE, acc);
    check("held_paint_accept_edge", acc == clr_acc + W * H + 1, acc, clr_acc + W * H + 1);

    do_paint($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(1, 15));

    // 6: reset in the middle of a clear
    @(negedge clk);
    clear_req = 1'b1;
    #1;
    clr_acc = cyc + 1;
    push_clear(clr_acc);
    @(posedge clk); #1;
    clear_req = 1'b0;
    waited = 0;
    do begin
      @(negedge clk); #1;
      waited++;
    end while (!(wr_en && wr_addr == 6'd20) && waited < 200);
    check("reach_addr_20", wr_en && wr_addr == 6'd20, wr_addr, 20);
    #2;
    reset = 1'b1;
    #1;
    check("async_abort_wr_en", wr_en == 1'b0, wr_en, 0);
    check("async_abort_busy", busy == 1'b0, busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_ready", paint_ready == 1'b1, paint_ready, 1);
    check("post_reset_wr_addr", wr_addr == 6'd0, wr_addr, 0);
    repeat (20) @(negedge clk);
    #1;
    check("post_reset_idle", busy == 1'b0, busy, 0);

    do_paint($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(1, 15));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
